syn_fifo_v2: RTL
================

Name: syn_fifo_v2

Overview:
Parametrised single-clock FIFO, the successor to our basic synchronous FIFO. Adds a compile-time read mode (standard registered read or first-word-fall-through), runtime-programmable almost-full/almost-empty thresholds, an occupancy count output, and sticky overflow/underflow error flags. It sits between a producer and a consumer that share one clock domain.

Parameters:
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
DATA_WIDTH, 8, word width in bits.
FWFT, 0, read mode: 0 = standard (data one cycle after rd_en), 1 = first-word-fall-through.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  synchronous, active-low reset.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write word.
wr_ready  out  1  high when a write will be accepted (= !full).
rd_en  in  1  standard mode: read request; FWFT mode: pop/acknowledge of the presented word.
rd_data  out  DATA_WIDTH  read word (registered).
rd_valid  out  1  rd_data holds a valid word.
af_thresh  in  ADDR_WIDTH+1  almost-full threshold.
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold.
count  out  ADDR_WIDTH+1  words held, 0..DEPTH.
full, empty  out  1 each  count==DEPTH, count==0.
almost_full  out  1  count >= af_thresh.
almost_empty  out  1  count <= ae_thresh.
overflow, underflow  out  1 each  sticky error flags.
clr_err  in  1  clears overflow and underflow.
par_inj  in  1  parity error inject (optional feature).
parity_err  out  1  parity error on the read word (optional feature).

Behaviour:
- Reset (rst_n=0 at a rising edge): pointers=0, count=0, empty=1, full=0, wr_ready=1, rd_valid=0, rd_data=0, overflow=0, underflow=0, parity_err=0. almost_full/almost_empty track count against thresholds combinationally, so after reset they equal (af_thresh==0) and 1. Memory contents are not cleared. Reset mid-operation discards all stored words.
- Pointers are ADDR_WIDTH+1 bits. The MSB distinguishes full from empty on wrap. Natural modulo wrap.
- Write accept = wr_en && !full. The word is stored and the write pointer advances at that edge.
- Read accept = rd_en && !empty (standard mode) or rd_en && rd_valid (FWFT mode).
- Count update per edge: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Full FIFO, wr_en and rd_en together: the write is refused (wr_ready=0), the read is accepted, count goes DEPTH -> DEPTH-1, and overflow is set.
- Empty FIFO, standard mode, wr_en and rd_en together: the write is accepted, the read is refused, underflow is set, and count becomes 1.
- Standard mode: an accepted read at edge N loads rd_data at edge N, and rd_valid=1 for exactly the following cycle. rd_valid=0 when no read is accepted. rd_data holds its last value.
- FWFT mode: the head word is always presented with rd_valid = !empty.
  - A write into an empty FIFO at edge N bypasses memory: rd_data=wr_data and rd_valid=1 immediately after edge N.
  - An accepted pop at edge N presents the next word after edge N (zero bubble), or drops rd_valid if the FIFO becomes empty.
  - The presented word counts toward count; total capacity is DEPTH.
- overflow is set by wr_en && full. underflow is set by rd_en with the read refused. Both hold until clr_err=1 or reset. If clr_err and a new error occur on the same edge, the new error wins (flag stays 1).
- Ordering is strict FIFO across all modes and wraps.

Optional Feature:
SYN_FIFO_PARITY_EN.
- Defined: memory width is DATA_WIDTH+1. The extra bit stores the even parity of wr_data, inverted when par_inj=1 on the write.
  - On read, parity is recomputed; parity_err is high exactly while rd_valid presents a word whose stored parity mismatches.
  - Standard mode: a one-cycle pulse aligned with rd_valid. FWFT mode: level while that word is presented.
- Undefined: memory width is DATA_WIDTH, par_inj is ignored, and parity_err is tied 0.

Test Plan:
- All tests use ADDR_WIDTH=4, DATA_WIDTH=8, af_thresh=12, ae_thresh=4.
- FWFT=0: write 1..16 back-to-back.
  - almost_empty falls after the 5th write; almost_full rises after the 12th.
  - After the 16th write: full=1, wr_ready=0, count=16.
  - A 17th wr_en sets overflow=1 and leaves count=16.
- FWFT=0: read 16 words. rd_data=1..16 in order, each with a one-cycle rd_valid in the cycle after its rd_en. empty=1 after the last read. An extra rd_en sets underflow=1 with rd_valid=0. clr_err clears both flags.
- FWFT=1, empty: write 0xA5 at edge N.
  - rd_valid=1 and rd_data=0xA5 right after edge N, count=1.
  - Write 0x5A, then pop at edge M: rd_data=0x5A after edge M. A second pop gives rd_valid=0, empty=1.
- Simultaneous wr/rd: at count=5, count stays 5 and order is preserved. At count=16, the read is accepted, the write is refused, overflow=1, count=15. At count=0 in standard mode, the write is accepted, underflow=1, count=1.
- Wrap and reset: 40 interleaved random writes/reads with a scoreboard show no mismatch across pointer wrap. rst_n=0 for one edge at count=7 gives count=0, empty=1, rd_valid=0, flags 0 after that edge.
- SYN_FIFO_PARITY_EN:
  - Defined: writing 0x3C with par_inj=1, then reading it, gives parity_err=1 aligned with rd_valid for 0x3C. Other words give parity_err=0.
  - Undefined: parity_err stays 0 throughout.

Source files
------------

// File: rtl/syn_fifo_v2.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/empty, occupancy count and sticky errors. Optional parity: SYN_FIFO_PARITY_EN.
module syn_fifo_v2 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err,
  input  logic                  par_inj,
  output logic                  parity_err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef SYN_FIFO_PARITY_EN
  localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int MEM_WIDTH = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [MEM_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [MEM_WIDTH-1:0]  wr_word, rd_word, head_word;
  logic                  wr_acc, rd_acc, head_load;

  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign wr_ready     = !full;
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

  assign wr_acc     = wr_en && !full;
  assign rd_acc     = rd_en && ((FWFT != 0) ? rd_valid : !empty);
  assign wr_ptr_nxt = wr_acc ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  assign rd_word    = mem[rd_ptr[ADDR_WIDTH-1:0]];

`ifdef SYN_FIFO_PARITY_EN
  assign wr_word = {^wr_data ^ par_inj, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // FWFT head: the presented word stays in memory (it counts toward capacity);
  // when the new head is the word being written this edge, take it from wr_data.
  always_comb begin
    head_load = (rd_acc || empty) && (count_nxt != '0);
    head_word = mem[rd_ptr_nxt[ADDR_WIDTH-1:0]];
    if (rd_ptr_nxt == wr_ptr) head_word = wr_word;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (FWFT != 0) begin
        rd_valid <= (count_nxt != '0);
        if (head_load) rd_data <= head_word[DATA_WIDTH-1:0];
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= rd_word[DATA_WIDTH-1:0];
      end
      // a new error on the same edge as clr_err keeps the flag set
      if (wr_en && full)        overflow <= 1'b1;
      else if (clr_err)         overflow <= 1'b0;
      if (rd_en && !rd_acc)     underflow <= 1'b1;
      else if (clr_err)         underflow <= 1'b0;
    end
  end

`ifdef SYN_FIFO_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (FWFT != 0) begin
      if (count_nxt == '0)  parity_err <= 1'b0;
      else if (head_load)   parity_err <= ^head_word;
    end else begin
      parity_err <= rd_acc && (^rd_word);
    end
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign parity_err     = 1'b0;
`endif

endmodule
